// File: rtl/seg_pkg.sv
// Shared constants and types for the six-digit seven-segment scan driver.
// Segment patterns are active-high here; polarity is applied by the driver.
package seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int NIBBLE_W   = 4;
  localparam int DATA_W     = NUM_DIGITS * NIBBLE_W;

  // Bit positions inside the 8-bit segment word {dp,g,f,e,d,c,b,a}.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Digit index; three bits cover digits 0..5.
  typedef logic [2:0] digit_idx_t;

  // Hex to segment table, active-high, dp bit clear.
  localparam logic [7:0] HEX_TABLE [0:15] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment pattern, active-high, dp merged
// into the top bit.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  input  logic                dp,
  output logic [7:0]          pattern
);

  logic [7:0] glyph;

  // Look up the glyph and OR the decimal point into its own bit.
  always_comb begin
    glyph                  = HEX_TABLE[nibble];
    pattern                = 8'h00;
    pattern[SEG_G:SEG_A]   = glyph[SEG_G:SEG_A];
    pattern[SEG_DP]        = dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed six-digit seven-segment driver. Data, enables and points
// are snapshotted once per frame; each digit slot starts with a short blank
// interval against ghosting. Optional build macro SEG_LEADING_ZERO_BLANK_EN
// blanks leading zero digits (digit 0 and digits with a point are kept).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int EN_ACTIVE_LOW  = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_W-1:0]     Data,
  input  logic [NUM_DIGITS-1:0] DisplayEnables,
  input  logic [NUM_DIGITS-1:0] Points,
  output logic [7:0]            Segs,
  output logic [NUM_DIGITS-1:0] En,
  output logic                  FrameDone
);

  localparam int                    PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]         PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam digit_idx_t            LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF     = (EN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]         prescaler;
  digit_idx_t            index;
  logic                  reload;
  logic [DATA_W-1:0]     shadow_data;
  logic [NUM_DIGITS-1:0] shadow_en;
  logic [NUM_DIGITS-1:0] shadow_pts;

  logic                  slot_end;
  logic                  frame_end;
  logic                  in_blank;
  logic [DATA_W-1:0]     cur_data;
  logic [NUM_DIGITS-1:0] cur_en;
  logic [NUM_DIGITS-1:0] cur_pts;
  logic [NIBBLE_W-1:0]   nibbles [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] show_mask;
  logic [NUM_DIGITS-1:0] onehot;
  logic [7:0]            seg_pattern;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] en_next;

  assign slot_end  = (prescaler == PRE_LAST);
  assign frame_end = slot_end && (index == LAST_DIGIT);
  assign in_blank  = (int'(prescaler) < BLANK_CYC);

  // Scan timing and frame snapshot; reset aborts the frame and arms a reload.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      prescaler   <= '0;
      index       <= '0;
      reload      <= 1'b1;
      // NOTE: the shadows are plain registers, not a memory, so resetting them
      // costs nothing and keeps the first blank slot deterministic.
      shadow_data <= '0;
      shadow_en   <= '0;
      shadow_pts  <= '0;
    end else begin
      prescaler <= slot_end ? '0 : prescaler + 1'b1;
      if (slot_end) begin
        index <= (index == LAST_DIGIT) ? '0 : index + 1'b1;
      end
      if (reload || frame_end) begin
        shadow_data <= Data;
        shadow_en   <= DisplayEnables;
        shadow_pts  <= Points;
      end
      reload <= 1'b0;
    end
  end

  // On the reload cycle the shadows still hold reset values, so the digit-0
  // output computed that cycle takes the live inputs being captured.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cur_data = shadow_data;
    cur_en   = shadow_en;
    cur_pts  = shadow_pts;
    if (reload) begin
      cur_data = Data;
      cur_en   = DisplayEnables;
      cur_pts  = Points;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nibble
    assign nibbles[g] = cur_data[g*NIBBLE_W +: NIBBLE_W];
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic seen_nonzero;

  // Walk from the top digit down; a digit shows once a nonzero nibble has
  // been seen at or above it, or if it is digit 0, or if it carries a point.
  always_comb begin
    seen_nonzero = 1'b0;
    show_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nonzero = seen_nonzero | (nibbles[i] != '0);
      show_mask[i] = cur_en[i] & (seen_nonzero | (i == 0) | cur_pts[i]);
    end
  end
`else
  assign show_mask = cur_en;
`endif

  seg_hex_decode u_decode (
    .nibble  (nibbles[index]),
    .dp      (cur_pts[index]),
    .pattern (seg_pattern)
  );

  assign onehot = NUM_DIGITS'(1) << index;

  // Next slot outputs: all off during the blank interval or for a hidden digit.
  always_comb begin
    seg_next = SEG_OFF;
    en_next  = EN_OFF;
    if (!in_blank && show_mask[index]) begin
      seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_pattern : seg_pattern;
      en_next  = (EN_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  // Output registers, one cycle behind the scan state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Segs      <= SEG_OFF;
      En        <= EN_OFF;
      FrameDone <= 1'b0;
    end else begin
      Segs      <= seg_next;
      En        <= en_next;
      FrameDone <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with SCAN_DIV=4, BLANK_CYC=1.
// Expected outputs are queued against absolute cycle numbers relative to the
// last reset edge; a negedge monitor pops and compares them.
module tb_seg_scan_driver;
  import seg_pkg::*;

  logic                  Clock = 1'b0;
  logic                  Reset = 1'b1;
  logic [DATA_W-1:0]     Data = '0;
  logic [NUM_DIGITS-1:0] DisplayEnables = '0;
  logic [NUM_DIGITS-1:0] Points = '0;
  logic [7:0]            Segs;
  logic [NUM_DIGITS-1:0] En;
  logic                  FrameDone;

  seg_scan_driver #(
    .SCAN_DIV       (4),
    .BLANK_CYC      (1),
    .SEG_ACTIVE_LOW (1),
    .EN_ACTIVE_LOW  (1)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Data           (Data),
    .DisplayEnables (DisplayEnables),
    .Points         (Points),
    .Segs           (Segs),
    .En             (En),
    .FrameDone      (FrameDone)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int         cyc;
    logic [7:0] segs;
    logic [5:0] en;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;
  int   cyc        = 0;
  int   anchor     = 0;
  bit   armed      = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int k, logic [7:0] segs, logic [5:0] en, logic fd, string tag);
    exp_t e;
    e.cyc  = anchor + k;
    e.segs = segs;
    e.en   = en;
    e.fd   = fd;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge Clock);
  endtask

  // Monitor: one-hot invariant every cycle, scoreboard entries on their cycle.
  always @(negedge Clock) begin
    exp_t e;
    if (armed) check("one_hot_en", 32'($countones(~En) > 1), 32'd0);
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      if (e.cyc < cyc) begin
        check({e.tag, "_missed"}, cyc, e.cyc);
      end else begin
        check({e.tag, "_segs"}, 32'(Segs), 32'(e.segs));
        check({e.tag, "_en"}, 32'(En), 32'(e.en));
        check({e.tag, "_fd"}, 32'(FrameDone), 32'(e.fd));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Reset hold, then first frame of 12AB5F with every digit enabled.
    @(negedge Clock);
    Data = 24'h12AB5F; DisplayEnables = 6'h3F; Points = 6'h00; Reset = 1'b1;
    anchor = cyc + 3;
    push(-2, 8'hFF, 6'h3F, 1'b0, "a_rst0");
    push(-1, 8'hFF, 6'h3F, 1'b0, "a_rst1");
    push( 0, 8'hFF, 6'h3F, 1'b0, "a_rst2");
    push( 1, 8'hFF, 6'h3F, 1'b0, "a_blank0");
    push( 2, ~8'h71, 6'b111110, 1'b0, "a_slot0");
    push( 4, ~8'h71, 6'b111110, 1'b0, "a_slot0_end");
    push( 5, 8'hFF, 6'h3F, 1'b0, "a_blank1");
    push( 6, ~8'h6D, 6'b111101, 1'b0, "a_slot1");
    push(10, ~8'h7C, 6'b111011, 1'b0, "a_slot2");
    push(21, 8'hFF, 6'h3F, 1'b0, "a_blank5");
    push(22, ~8'h06, 6'b011111, 1'b0, "a_slot5");
    push(23, ~8'h06, 6'b011111, 1'b0, "a_fd_before");
    push(24, ~8'h06, 6'b011111, 1'b1, "a_fd_first");
    push(25, 8'hFF, 6'h3F, 1'b0, "a_fd_after");
    push(26, ~8'h71, 6'b111110, 1'b0, "a_f1_slot0");
    wait_cyc(anchor - 2);
    armed = 1'b1;
    wait_cyc(anchor);
    Reset = 1'b0;
    wait_cyc(anchor + 27);

    // Data changes during slot 2 stay hidden until the next frame.
    Data = 24'h000000; Reset = 1'b1;
    anchor = cyc + 1;
    push( 0, 8'hFF, 6'h3F, 1'b0, "b_rst");
    push(10, ~8'h3F, 6'b111011, 1'b0, "b_slot2");
    push(14, ~8'h3F, 6'b110111, 1'b0, "b_slot3_old");
    push(22, ~8'h3F, 6'b011111, 1'b0, "b_slot5_old");
    push(24, ~8'h3F, 6'b011111, 1'b1, "b_fd");
    push(26, ~8'h71, 6'b111110, 1'b0, "b_f1_slot0");
    push(30, ~8'h71, 6'b111101, 1'b0, "b_f1_slot1");
    push(46, ~8'h71, 6'b011111, 1'b0, "b_f1_slot5");
    wait_cyc(anchor);
    Reset = 1'b0;
    wait_cyc(anchor + 10);
    Data = 24'hFFFFFF;
    wait_cyc(anchor + 47);

    // Sparse enables and a decimal point on digit 1.
    Data = 24'h654321; DisplayEnables = 6'b101010; Points = 6'b000010; Reset = 1'b1;
    anchor = cyc + 1;
    push( 2, 8'hFF, 6'h3F, 1'b0, "c_slot0_off");
    push( 5, 8'hFF, 6'h3F, 1'b0, "c_blank1");
    push( 6, ~8'hDB, 6'b111101, 1'b0, "c_slot1_dp");
    push( 8, ~8'hDB, 6'b111101, 1'b0, "c_slot1_end");
    push( 9, 8'hFF, 6'h3F, 1'b0, "c_blank2");
    push(10, 8'hFF, 6'h3F, 1'b0, "c_slot2_off");
    push(14, ~8'h66, 6'b110111, 1'b0, "c_slot3");
    push(18, 8'hFF, 6'h3F, 1'b0, "c_slot4_off");
    push(22, ~8'h7D, 6'b011111, 1'b0, "c_slot5");
    push(24, ~8'h7D, 6'b011111, 1'b1, "c_fd");
    push(38, ~8'h66, 6'b110111, 1'b0, "c_f1_slot3");
    wait_cyc(anchor);
    Reset = 1'b0;

    // One-cycle reset in the middle of frame 1 slot 3, new content behind it.
    wait_cyc(anchor + 38);
    Reset = 1'b1; Data = 24'h000777; DisplayEnables = 6'h3F; Points = 6'h00;
    anchor = anchor + 39;
    push( 0, 8'hFF, 6'h3F, 1'b0, "d_rst");
    push( 1, 8'hFF, 6'h3F, 1'b0, "d_blank0");
    push( 2, ~8'h07, 6'b111110, 1'b0, "d_slot0");
    push( 6, ~8'h07, 6'b111101, 1'b0, "d_slot1");
    push( 9, 8'hFF, 6'h3F, 1'b0, "d_no_stale_fd");
    push(10, ~8'h07, 6'b111011, 1'b0, "d_slot2");
    push(14, ~8'h3F, 6'b110111, 1'b0, "d_slot3");
    push(24, ~8'h3F, 6'b011111, 1'b1, "d_fd");
    wait_cyc(anchor);
    Reset = 1'b0;
    wait_cyc(anchor + 25);

    // Leading zeros: 0003A0, then 000000 in the following frame.
    Data = 24'h0003A0; Reset = 1'b1;
    anchor = cyc + 1;
    push( 2, ~8'h3F, 6'b111110, 1'b0, "e_slot0");
    push( 6, ~8'h77, 6'b111101, 1'b0, "e_slot1");
    push(10, ~8'h4F, 6'b111011, 1'b0, "e_slot2");
`ifdef SEG_LEADING_ZERO_BLANK_EN
    push(14, 8'hFF, 6'h3F, 1'b0, "e_slot3_lz");
    push(18, 8'hFF, 6'h3F, 1'b0, "e_slot4_lz");
    push(22, 8'hFF, 6'h3F, 1'b0, "e_slot5_lz");
    push(24, 8'hFF, 6'h3F, 1'b1, "e_fd");
    push(26, ~8'h3F, 6'b111110, 1'b0, "e_zero_slot0");
    push(30, 8'hFF, 6'h3F, 1'b0, "e_zero_slot1_lz");
    push(34, 8'hFF, 6'h3F, 1'b0, "e_zero_slot2_lz");
    push(46, 8'hFF, 6'h3F, 1'b0, "e_zero_slot5_lz");
`else
    push(14, ~8'h3F, 6'b110111, 1'b0, "e_slot3");
    push(22, ~8'h3F, 6'b011111, 1'b0, "e_slot5");
    push(24, ~8'h3F, 6'b011111, 1'b1, "e_fd");
    push(26, ~8'h3F, 6'b111110, 1'b0, "e_zero_slot0");
    push(30, ~8'h3F, 6'b111101, 1'b0, "e_zero_slot1");
    push(46, ~8'h3F, 6'b011111, 1'b0, "e_zero_slot5");
`endif
    wait_cyc(anchor);
    Reset = 1'b0;
    wait_cyc(anchor + 5);
    Data = 24'h000000;
    wait_cyc(anchor + 48);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
